// File: rtl/pb_debounce.sv
// -----------------------------------------------------------------------------
// pb_debounce
//
// Purpose
//   Four-channel pushbutton conditioner. Each raw pin is brought into the clk
//   domain through a two-flop synchroniser and then filtered by a per-channel
//   four-state FSM with a 16-bit stability counter. A new level is accepted
//   only after STABLE_CNT consecutive synchronised samples agree. Any opposite
//   sample restarts the count. The debounced level and one-cycle press/release
//   pulses are registered outputs.
//
//   Optional long-press detection is compiled in with the macro
//   PB_LONG_PRESS_EN. When the macro is defined, each channel gets a 32-bit
//   saturating hold counter, and pb_long pulses once per press after the
//   debounced level has stayed high long enough. When the macro is not
//   defined, pb_long is tied to zero and nothing else changes.
//
// Parameters
//   STABLE_CNT : consecutive agreeing samples needed to accept a change (2..65535)
//   LONG_CNT   : hold time in cycles before a long-press pulse (2..2^32-1)
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   rst        : asynchronous, active-low reset
//   pb_raw     : [3:0] raw asynchronous button pins, 1 = pressed
//   pb_level   : [3:0] debounced, registered button level
//   pb_press   : [3:0] one-cycle pulse on each accepted 0->1 transition
//   pb_release : [3:0] one-cycle pulse on each accepted 1->0 transition
//   pb_long    : [3:0] one-cycle long-press pulse (zero unless PB_LONG_PRESS_EN)
//
// Timing
//   A clean raw edge moves pb_level/pb_press exactly STABLE_CNT+2 cycles
//   later: two cycles in the synchroniser, then STABLE_CNT filter samples.
// -----------------------------------------------------------------------------
module pb_debounce #(
    parameter int unsigned STABLE_CNT = 50000,
    parameter int unsigned LONG_CNT   = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] pb_raw,
    output logic [3:0] pb_level,
    output logic [3:0] pb_press,
    output logic [3:0] pb_release,
    output logic [3:0] pb_long
);

    // The filter is complete when the counter reaches this value.
    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CNT - 1);

    // Reject parameter values that the counter widths cannot represent.
    if (STABLE_CNT < 2 || STABLE_CNT > 65535) begin : g_bad_stable_cnt
        $error("pb_debounce: STABLE_CNT out of range 2..65535");
    end
    if (LONG_CNT < 2) begin : g_bad_long_cnt
        $error("pb_debounce: LONG_CNT must be at least 2");
    end

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_PEND   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_PEND = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser. Only the second stage is used by the filters.
    // -------------------------------------------------------------------------
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= pb_raw;
            r_sync2 <= r_sync1;
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel filter
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        state_t      r_state;
        state_t      w_state_next;
        logic [15:0] r_cnt;
        logic [15:0] w_cnt_next;
        logic        r_level;
        logic        w_level_next;
        logic        r_press;
        logic        w_press_next;
        logic        r_release;
        logic        w_release_next;
        logic        w_sync;

        assign w_sync = r_sync2[gi];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state   <= S_RELEASED;
                r_cnt     <= 16'd0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_state   <= w_state_next;
                r_cnt     <= w_cnt_next;
                r_level   <= w_level_next;
                r_press   <= w_press_next;
                r_release <= w_release_next;
            end
        end

        always_comb begin
            w_state_next   = r_state;
            w_cnt_next     = r_cnt;
            w_level_next   = r_level;
            w_press_next   = 1'b0;
            w_release_next = 1'b0;

            case (r_state)
                S_RELEASED: begin
                    if (w_sync) begin
                        w_state_next = S_PRESS_PEND;
                        w_cnt_next   = 16'd0;
                    end
                end

                S_PRESS_PEND: begin
                    if (!w_sync) begin
                        w_state_next = S_RELEASED;
                        w_cnt_next   = 16'd0;
                    end else if (r_cnt >= STABLE_LAST - 16'd1) begin
                        // The entry sample plus STABLE_CNT-1 increments make
                        // STABLE_CNT agreeing samples. The counter stops at
                        // STABLE_LAST and never wraps.
                        w_state_next = S_PRESSED;
                        w_cnt_next   = STABLE_LAST;
                        w_level_next = 1'b1;
                        w_press_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 16'd1;
                    end
                end

                S_PRESSED: begin
                    if (!w_sync) begin
                        w_state_next = S_RELEASE_PEND;
                        w_cnt_next   = 16'd0;
                    end
                end

                S_RELEASE_PEND: begin
                    if (w_sync) begin
                        // The release was only a bounce. The level never
                        // dropped, so no pulse is emitted.
                        w_state_next = S_PRESSED;
                        w_cnt_next   = 16'd0;
                    end else if (r_cnt >= STABLE_LAST - 16'd1) begin
                        w_state_next   = S_RELEASED;
                        w_cnt_next     = STABLE_LAST;
                        w_level_next   = 1'b0;
                        w_release_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 16'd1;
                    end
                end

                default: begin
                    w_state_next = S_RELEASED;
                    w_cnt_next   = 16'd0;
                    w_level_next = 1'b0;
                end
            endcase
        end

        assign pb_level[gi]   = r_level;
        assign pb_press[gi]   = r_press;
        assign pb_release[gi] = r_release;

`ifdef PB_LONG_PRESS_EN
        // The hold counter is cleared only when a press is accepted. A
        // release bounce that returns to PRESSED therefore continues the same
        // hold, so the long pulse still fires at most once per press.
        localparam logic [31:0] LONG_LAST = 32'(LONG_CNT - 1);

        logic [31:0] r_lcnt;
        logic [31:0] w_lcnt_next;
        logic        r_long;
        logic        w_long_next;
        logic        w_held;

        assign w_held = (r_state == S_PRESSED) || (r_state == S_RELEASE_PEND);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_lcnt <= 32'd0;
                r_long <= 1'b0;
            end else begin
                r_lcnt <= w_lcnt_next;
                r_long <= w_long_next;
            end
        end

        always_comb begin
            w_lcnt_next = r_lcnt;
            w_long_next = 1'b0;
            if (w_press_next) begin
                w_lcnt_next = 32'd0;
            end else if (w_held && (r_lcnt != 32'hFFFF_FFFF)) begin
                w_lcnt_next = r_lcnt + 32'd1;
            end
            // The counter passes LONG_LAST only once per press. LONG_LAST is
            // at most 2^32-2, so the saturated value can never match it.
            if (w_held && (r_lcnt == LONG_LAST)) begin
                w_long_next = 1'b1;
            end
        end

        assign pb_long[gi] = r_long;
`else
        assign pb_long[gi] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_pb_debounce.sv
// -----------------------------------------------------------------------------
// tb_pb_debounce
//
// Directed bench for pb_debounce with STABLE_CNT=4 and LONG_CNT=10. Inputs
// are driven on the falling edge. Outputs are sampled on the falling edge as
// one packed vector {pb_level, pb_press, pb_release, pb_long}. Long-press
// expectations follow PB_LONG_PRESS_EN.
// -----------------------------------------------------------------------------
module tb_pb_debounce;

    localparam int STABLE = 4;
    localparam int LONG   = 10;

`ifdef PB_LONG_PRESS_EN
    localparam logic [3:0] LONG_CH2 = 4'h4;
`else
    localparam logic [3:0] LONG_CH2 = 4'h0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pb_raw = 4'h0;
    logic [3:0] pb_level;
    logic [3:0] pb_press;
    logic [3:0] pb_release;
    logic [3:0] pb_long;

    int n_cmp = 0;
    int n_err = 0;

    pb_debounce #(
        .STABLE_CNT (STABLE),
        .LONG_CNT   (LONG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pb_raw     (pb_raw),
        .pb_level   (pb_level),
        .pb_press   (pb_press),
        .pb_release (pb_release),
        .pb_long    (pb_long)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pack4(input logic [3:0] l, input logic [3:0] p,
                                          input logic [3:0] r, input logic [3:0] g);
        return {l, p, r, g};
    endfunction

    task automatic chk(input string tag, input logic [15:0] expv);
        logic [15:0] obs;
        obs = {pb_level, pb_press, pb_release, pb_long};
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed lvl/prs/rel/lng=%h required %h", tag, obs, expv);
        end
        $display("check %-14s raw=%h obs=%h exp=%h", tag, pb_raw, obs, expv);
    endtask

    task automatic step_chk(input string tag, input logic [15:0] expv);
        @(negedge clk);
        chk(tag, expv);
    endtask

    logic bounce_seq [5];

    initial begin
        bounce_seq[0] = 1'b1;
        bounce_seq[1] = 1'b0;
        bounce_seq[2] = 1'b1;
        bounce_seq[3] = 1'b1;
        bounce_seq[4] = 1'b0;

        // Reset with all buttons held. The outputs must be zero at once.
        #2 rst = 1'b0;
        pb_raw = 4'hF;
        #1 chk("rst_async", 16'h0);
        step_chk("rst_hold", 16'h0);
        step_chk("rst_hold", 16'h0);

        // Release reset. The held buttons count as a new press 6 cycles later.
        rst = 1'b1;
        for (int i = 1; i <= STABLE + 1; i++) step_chk("rst_wait", 16'h0);
        step_chk("rst_press", pack4(4'hF, 4'hF, 4'h0, 4'h0));
        step_chk("rst_after", pack4(4'hF, 4'h0, 4'h0, 4'h0));
        pb_raw = 4'h0;
        for (int i = 1; i <= STABLE + 1; i++) step_chk("rst_relpend", pack4(4'hF, 4'h0, 4'h0, 4'h0));
        step_chk("rst_release", pack4(4'h0, 4'h0, 4'hF, 4'h0));
        step_chk("rst_idle", 16'h0);

        // Clean press on channel 0.
        pb_raw = 4'h1;
        for (int i = 1; i <= STABLE + 1; i++) step_chk("press_wait", 16'h0);
        step_chk("press_pulse", pack4(4'h1, 4'h1, 4'h0, 4'h0));
        step_chk("press_hold", pack4(4'h1, 4'h0, 4'h0, 4'h0));

        // Clean release on channel 0.
        pb_raw = 4'h0;
        for (int i = 1; i <= STABLE + 1; i++) step_chk("release_wait", pack4(4'h1, 4'h0, 4'h0, 4'h0));
        step_chk("release_pulse", pack4(4'h0, 4'h0, 4'h1, 4'h0));
        step_chk("release_idle", 16'h0);

        // Bounce on channel 1. No run of ones is long enough to be accepted.
        for (int i = 0; i < 5; i++) begin
            pb_raw = {2'b00, bounce_seq[i], 1'b0};
            step_chk("bounce", 16'h0);
        end
        pb_raw = 4'h0;
        for (int i = 0; i < 10; i++) step_chk("bounce_settle", 16'h0);

        // Long press on channel 2. The long pulse comes 10 cycles after the
        // press pulse.
        pb_raw = 4'h4;
        for (int i = 1; i <= STABLE + 1; i++) step_chk("long_wait", 16'h0);
        step_chk("long_press", pack4(4'h4, 4'h4, 4'h0, 4'h0));
        for (int k = 1; k <= 20; k++)
            step_chk("long_hold", pack4(4'h4, 4'h0, 4'h0, (k == LONG) ? LONG_CH2 : 4'h0));
        pb_raw = 4'h0;
        for (int i = 1; i <= STABLE + 1; i++) step_chk("long_relpend", pack4(4'h4, 4'h0, 4'h0, 4'h0));
        step_chk("long_release", pack4(4'h0, 4'h0, 4'h4, 4'h0));
        step_chk("long_idle", 16'h0);

        // Reset during PRESS_PEND on channel 3. The partial press is discarded.
        pb_raw = 4'h8;
        for (int i = 0; i < 3; i++) step_chk("mid_pend", 16'h0);
        rst    = 1'b0;
        pb_raw = 4'h0;
        #1 chk("mid_rst", 16'h0);
        step_chk("mid_rst_hold", 16'h0);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) step_chk("mid_after", 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pb_debounce.md
PB_DEBOUNCE -- requirements
Module: pb_debounce

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 50000, the number of consecutive cycles a synchronised input must hold a new value before it is accepted (range 2..65535).
REQ-002 SHALL have parameter LONG_CNT, default 50000000, the number of cycles the debounced level must stay high before a long-press pulse (range 2..2^32-1).
REQ-003 SHALL have port clk, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port pb_raw, input, 4 bits: raw, asynchronous pushbutton pins (1 = pressed).
REQ-006 SHALL have port pb_level, output, 4 bits: debounced, registered button level.
REQ-007 SHALL have port pb_press, output, 4 bits: one-cycle pulse per channel on each accepted 0->1 transition.
REQ-008 SHALL have port pb_release, output, 4 bits: one-cycle pulse per channel on each accepted 1->0 transition.
REQ-009 SHALL have port pb_long, output, 4 bits: one-cycle long-press pulse per channel (see Configuration).

Function
REQ-010 SHALL pass each pb_raw bit through a 2-flop synchroniser; only the second flop output (sync) feeds the filter.
REQ-011 SHALL give each channel an independent FSM with states RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND and a 16-bit stability counter.
REQ-012 SHALL move RELEASED->PRESS_PEND with counter cleared to 0 when sync=1; PRESS_PEND returns to RELEASED with counter cleared when sync=0.
REQ-013 SHALL, in PRESS_PEND with sync=1, increment the counter and move to PRESSED on the edge where it reaches STABLE_CNT-1, setting pb_level=1 and pb_press=1 for that one cycle.
REQ-014 SHALL mirror REQ-012/013 for release: PRESSED->RELEASE_PEND on sync=0; accept after STABLE_CNT consecutive sync=0 cycles, setting pb_level=0 and pb_release=1 for one cycle.
REQ-015 SHALL give a latency from a clean pb_raw edge to the pb_level/pb_press change of exactly STABLE_CNT+2 cycles.
REQ-016 SHALL produce no output change for a glitch or bounce shorter than STABLE_CNT cycles; any opposite sample restarts the count from 0.
REQ-017 SHALL keep the counter non-wrapping: it never exceeds STABLE_CNT-1.
REQ-018 SHALL keep channels fully independent; simultaneous press/release pulses on several channels in one cycle are legal.
REQ-019 SHALL never assert pb_press and pb_release on the same channel in the same cycle.

Reset
REQ-020 SHALL, while rst=0, immediately clear synchroniser flops, counters and long counters, put every FSM in RELEASED, and drive pb_level, pb_press, pb_release and pb_long to 0.
REQ-021 SHALL discard a press or release that is in progress when reset asserts; no pulse is emitted for it.
REQ-022 SHALL treat a button held through reset deassertion as a new press: pb_press pulses STABLE_CNT+2 cycles after the first post-reset edge.

Configuration
REQ-023 SHALL, with macro PB_LONG_PRESS_EN defined, give each channel a 32-bit saturating counter that clears on entry to PRESSED and increments while in PRESSED or RELEASE_PEND; pb_long pulses for one cycle when the counter reaches LONG_CNT-1, at most once per press.
REQ-024 SHALL, without PB_LONG_PRESS_EN, omit the long counters and tie pb_long to 4'b0000; all other behaviour is identical.

Verification (STABLE_CNT=4, LONG_CNT=10)
REQ-025 SHALL check reset: rst=0 with pb_raw=4'hF gives all outputs 0; after rst=1, pb_press=4'hF pulses once and pb_level=4'hF, 6 cycles later.
REQ-026 SHALL check a clean press: pb_raw[0] rises and holds, giving pb_press=4'h1 for exactly one cycle 6 cycles later, with pb_level[0]=1 from that cycle on.
REQ-027 SHALL check bounce: pb_raw[1] toggles 1,0,1,1,0 cycle by cycle then stays 0, giving no pb_press/pb_level change on channel 1.
REQ-028 SHALL check release: channel 0 pressed, then pb_raw[0]=0 held, giving a pb_release[0] pulse 6 cycles later with pb_level[0]=0 and no pb_press.
REQ-029 SHALL check long press with PB_LONG_PRESS_EN: channel 2 held 20 cycles past pb_press gives exactly one pb_long[2] pulse, 10 cycles after pb_press[2]; without the macro, pb_long stays 0.
REQ-030 SHALL check reset mid-press: rst pulsed low during PRESS_PEND with pb_raw[3]=0 afterwards gives no pb_press[3] at any time.
